// File: rtl/pipe_reg_chain.sv
// Elastic pipeline register: DEPTH valid-tagged stages with collapsing bubbles, stall and flush.
// Optional `PIPE_REG_OCC_EN adds an occupancy output (popcount of the stage valid bits).
module pipe_reg_chain #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic             stall,
    input  logic             flush
`ifdef PIPE_REG_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);

    logic [DEPTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [WIDTH-1:0] d_d [DEPTH];
    logic [DEPTH:0]   rdy;

    // rdy[i] is built from the output side back, so a stage behind a bubble can always advance.
    always_comb begin
        logic r;
        r = out_ready;
        rdy = '0;
        rdy[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            r = ~v_q[i] | r;
            rdy[i] = r;
        end
    end

    always_comb begin
        v_d = v_q;
        d_d = d_q;
        if (flush) begin
            v_d = '0;
        end else if (!stall) begin
            if (rdy[0]) begin
                v_d[0] = in_valid;
                if (in_valid) d_d[0] = in_data;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) d_d[i] = d_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
        end else begin
            v_q <= v_d;
            d_q <= d_d;
        end
    end

    assign in_ready  = rdy[0] & ~stall & ~flush;
    assign out_valid = v_q[DEPTH-1] & ~stall & ~flush;
    assign out_data  = d_q[DEPTH-1];

`ifdef PIPE_REG_OCC_EN
    localparam int OCC_W = $clog2(DEPTH + 1);

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) occupancy = occupancy + OCC_W'(v_q[i]);
    end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: DEPTH=2, 3 and 4 instances driven by directed vectors.
`timescale 1ns/1ps
module tb_pipe_reg_chain;

    logic clk, rst;
    int   checks = 0;
    int   errors = 0;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall, a_flush;
    logic [7:0] a_in_data, a_out_data;
    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall, b_flush;
    logic [7:0] b_in_data, b_out_data;
    logic       c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_stall, c_flush;
    logic [7:0] c_in_data, c_out_data;
`ifdef PIPE_REG_OCC_EN
    logic [1:0] a_occ, b_occ;
    logic [2:0] c_occ;
`endif

    logic [7:0] qa[$], qb[$], qc[$];

    pipe_reg_chain #(.WIDTH(8), .DEPTH(2)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .stall(a_stall), .flush(a_flush)
`ifdef PIPE_REG_OCC_EN
        , .occupancy(a_occ)
`endif
    );

    pipe_reg_chain #(.WIDTH(8), .DEPTH(3)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .stall(b_stall), .flush(b_flush)
`ifdef PIPE_REG_OCC_EN
        , .occupancy(b_occ)
`endif
    );

    pipe_reg_chain #(.WIDTH(8), .DEPTH(4)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_data(c_in_data), .in_ready(c_in_ready),
        .out_valid(c_out_valid), .out_data(c_out_data), .out_ready(c_out_ready),
        .stall(c_stall), .flush(c_flush)
`ifdef PIPE_REG_OCC_EN
        , .occupancy(c_occ)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Output monitors: every output transfer must match the head of its queue.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_extra: got %0h, expected no output", a_out_data);
            end else check("a_out", a_out_data, qa.pop_front());
        end
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_extra: got %0h, expected no output", b_out_data);
            end else check("b_out", b_out_data, qb.pop_front());
        end
        if (!rst && c_out_valid && c_out_ready) begin
            if (qc.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_extra: got %0h, expected no output", c_out_data);
            end else check("c_out", c_out_data, qc.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [7:0] dat);
        a_in_valid = 1'b1;
        a_in_data  = dat;
        @(negedge clk);
        check("a_in_ready", a_in_ready, 1);
        qa.push_back(dat);
        step();
        a_in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 100us");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, nout, lat;
        rst = 1'b1;
        {a_in_valid, a_out_ready, a_stall, a_flush} = '0;
        {b_in_valid, b_out_ready, b_stall, b_flush} = '0;
        {c_in_valid, c_out_ready, c_stall, c_flush} = '0;
        a_in_data = '0; b_in_data = '0; c_in_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_out_data", a_out_data, 0);
`ifdef PIPE_REG_OCC_EN
        check("rst_occ", c_occ, 0);
`endif
        step();
        rst = 1'b0;

        // Reset with DEPTH=3 chain full, then latency of a fresh word.
        for (int k = 1; k <= 3; k++) begin
            b_in_valid = 1'b1;
            b_in_data  = 8'(k);
            step();
        end
        b_in_valid = 1'b0;
        @(negedge clk);
        check("b_full_in_ready", b_in_ready, 0);
        check("b_full_out_valid", b_out_valid, 1);
        check("b_full_out_data", b_out_data, 8'h01);
        #2 rst = 1'b1;
        #1;
        check("b_async_out_valid", b_out_valid, 0);
        check("b_async_out_data", b_out_data, 0);
        check("b_async_in_ready", b_in_ready, 1);
        step();
        rst = 1'b0;
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_in_data   = 8'hA5;
        qb.push_back(8'hA5);
        step();
        b_in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (b_out_valid) begin
                lat = n;
                break;
            end
        end
        check("b_latency", lat, 3);
        step();

        // Streaming, DEPTH=2.
        a_out_ready = 1'b1;
        first = -1;
        nout = 0;
        for (int c = 0; c < 12; c++) begin
            a_in_valid = (c < 8);
            a_in_data  = 8'(c + 1);
            @(negedge clk);
            if (c < 8) begin
                check("a_stream_rdy", a_in_ready, 1);
                qa.push_back(8'(c + 1));
            end
            if (a_out_valid) begin
                nout++;
                if (first < 0) first = c;
            end
            step();
        end
        a_in_valid = 1'b0;
        check("a_first_out", first, 2);
        check("a_stream_cnt", nout, 8);

        // Backpressure with a bubble between words.
        a_out_ready = 1'b0;
        send_a(8'h11);
        step();
        send_a(8'h22);
        @(negedge clk);
        check("a_bp_in_ready", a_in_ready, 0);
        check("a_bp_out_data", a_out_data, 8'h11);
        step();
        a_out_ready = 1'b1;
        @(negedge clk);
        check("a_bp_ready_same_cycle", a_in_ready, 1);
        step();
        step();
        check("a_bp_drain", qa.size(), 0);

        // Stall holds contents and masks handshakes.
        a_out_ready = 1'b0;
        send_a(8'h33);
        send_a(8'h44);
        a_stall = 1'b1;
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        a_in_data = 8'h99;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("a_stall_out_valid", a_out_valid, 0);
            check("a_stall_in_ready", a_in_ready, 0);
            step();
        end
        a_stall = 1'b0;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("a_stall_release_valid", a_out_valid, 1);
        check("a_stall_release_data", a_out_data, 8'h33);
        step();
        step();
        check("a_stall_drain", qa.size(), 0);

        // Flush wins over stall and drops the offered word.
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = 8'h66;
        step();
        a_in_data = 8'h77;
        step();
        a_flush = 1'b1;
        a_stall = 1'b1;
        a_out_ready = 1'b1;
        a_in_data = 8'h55;
        @(negedge clk);
        check("a_flush_in_ready", a_in_ready, 0);
        check("a_flush_out_valid", a_out_valid, 0);
        step();
        a_flush = 1'b0;
        a_stall = 1'b0;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("a_post_flush_valid", a_out_valid, 0);
        check("a_post_flush_in_ready", a_in_ready, 1);
        check("a_post_flush_data", a_out_data, 8'h66);
`ifdef PIPE_REG_OCC_EN
        check("a_post_flush_occ", a_occ, 0);
`endif
        step();
        @(negedge clk);
        check("a_flush_no_capture", a_out_valid, 0);
        step();

        // DEPTH=4 fill, then simultaneous accept and emit.
        c_out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            c_in_valid = 1'b1;
            c_in_data = 8'hC1 + 8'(k);
            @(negedge clk);
            check("c_fill_in_ready", c_in_ready, 1);
            qc.push_back(8'hC1 + 8'(k));
`ifdef PIPE_REG_OCC_EN
            check("c_fill_occ", c_occ, 3'(k));
`endif
            step();
        end
        c_in_valid = 1'b0;
        @(negedge clk);
        check("c_full_in_ready", c_in_ready, 0);
        check("c_full_out_valid", c_out_valid, 1);
`ifdef PIPE_REG_OCC_EN
        check("c_full_occ", c_occ, 4);
`endif
        step();
        c_out_ready = 1'b1;
        c_in_valid = 1'b1;
        c_in_data = 8'hC5;
        @(negedge clk);
        check("c_full_pass_in_ready", c_in_ready, 1);
        qc.push_back(8'hC5);
        step();
        c_in_valid = 1'b0;
        @(negedge clk);
        check("c_swap_out_data", c_out_data, 8'hC2);
`ifdef PIPE_REG_OCC_EN
        check("c_swap_occ", c_occ, 4);
`endif
        for (int n = 0; n < 20 && qc.size() != 0; n++) @(posedge clk);
        #1;
        check("c_drain", qc.size(), 0);
        check("a_final_drain", qa.size(), 0);
        check("b_final_drain", qb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
